// File: rtl/bp_me_wb_arbiter.sv
// N-master to 1-slave Wishbone B4 arbiter: round-robin grant, cyc bus lock,
// per-master response routing and a stall watchdog that ends hung cycles.
// Ports: clk_i/reset_i; m_* packed per-master bus (master 0 in LSBs);
//   s_* single slave-side bus; m_dat_o broadcasts s_dat_i.
module bp_me_wb_arbiter #(
  parameter int num_masters_p    = 2,
  parameter int data_width_p     = 64,
  parameter int addr_width_p     = 37,
  parameter int timeout_cycles_p = 255
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_masters_p*addr_width_p-1:0]     m_adr_i,
  input  logic [num_masters_p*data_width_p-1:0]     m_dat_i,
  input  logic [num_masters_p*(data_width_p/8)-1:0] m_sel_i,
  input  logic [num_masters_p-1:0]                  m_we_i,
  input  logic [num_masters_p-1:0]                  m_cyc_i,
  input  logic [num_masters_p-1:0]                  m_stb_i,
  input  logic [num_masters_p*3-1:0]                m_cti_i,
  input  logic [num_masters_p*2-1:0]                m_bte_i,
  output logic [data_width_p-1:0]                   m_dat_o,
  output logic [num_masters_p-1:0]                  m_ack_o,
  output logic [num_masters_p-1:0]                  m_err_o,
  output logic [num_masters_p-1:0]                  m_rty_o,
  output logic [addr_width_p-1:0]                   s_adr_o,
  output logic [data_width_p-1:0]                   s_dat_o,
  output logic [data_width_p/8-1:0]                 s_sel_o,
  output logic                                      s_we_o,
  output logic                                      s_cyc_o,
  output logic                                      s_stb_o,
  output logic [2:0]                                s_cti_o,
  output logic [1:0]                                s_bte_o,
  input  logic [data_width_p-1:0]                   s_dat_i,
  input  logic                                      s_ack_i,
  input  logic                                      s_err_i,
  input  logic                                      s_rty_i
);

  localparam int sel_w = data_width_p / 8;
  localparam int gw    = $clog2(num_masters_p);

  localparam logic [0:0] idle_s  = 1'b0;
  localparam logic [0:0] grant_s = 1'b1;

  logic [0:0]              state_r;
  logic [gw-1:0]           grant_r;
  logic [gw-1:0]           last_r;
  logic [gw-1:0]           next_grant;
  logic                    in_grant;
  logic                    wd_fire;
  logic                    resp;
  logic [num_masters_p-1:0] gmask;
  int                      gi;

  assign in_grant = (state_r == grant_s);
  assign gi       = int'(grant_r);
  assign resp     = s_ack_i | s_err_i | s_rty_i;

  // first requester after last_grant, wrapping around
  always_comb begin
    int idx;
    logic found;
    next_grant = last_r;
    found      = 1'b0;
    idx        = 0;
    for (int i = 1; i <= num_masters_p; i++) begin
      idx = (int'(last_r) + i) % num_masters_p;
      if (!found && m_cyc_i[idx]) begin
        found      = 1'b1;
        next_grant = gw'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= idle_s;
      grant_r <= '0;
      last_r  <= gw'(num_masters_p - 1);
    end else begin
      unique case (1'b1)
        (state_r == idle_s): begin
          if (|m_cyc_i) begin
            grant_r <= next_grant;
            state_r <= grant_s;
          end
        end
        default: begin
          if (!m_cyc_i[gi]) begin
            last_r  <= grant_r;
            state_r <= idle_s;
          end
        end
      endcase
    end
  end

  assign s_adr_o = in_grant ? m_adr_i[gi*addr_width_p +: addr_width_p] : '0;
  assign s_dat_o = in_grant ? m_dat_i[gi*data_width_p +: data_width_p] : '0;
  assign s_sel_o = in_grant ? m_sel_i[gi*sel_w +: sel_w] : '0;
  assign s_cti_o = in_grant ? m_cti_i[gi*3 +: 3] : '0;
  assign s_bte_o = in_grant ? m_bte_i[gi*2 +: 2] : '0;
  assign s_we_o  = in_grant & m_we_i[gi];

  // a watchdog abort or reset drops the slave cycle in the same clock
  assign s_cyc_o = in_grant & m_cyc_i[gi] & ~wd_fire & ~reset_i;
  assign s_stb_o = in_grant & m_stb_i[gi] & ~wd_fire & ~reset_i;

  always_comb begin
    gmask = '0;
    if (in_grant && !reset_i) gmask[gi] = 1'b1;
  end

  assign m_ack_o = gmask & {num_masters_p{s_ack_i}};
  assign m_err_o = gmask & {num_masters_p{s_err_i | wd_fire}};
  assign m_rty_o = gmask & {num_masters_p{s_rty_i}};
  assign m_dat_o = s_dat_i;

  if (timeout_cycles_p > 0) begin : g_wd
    localparam int cw = $clog2(timeout_cycles_p + 1);
    logic [cw-1:0] cnt_r;

    assign wd_fire = in_grant && (cnt_r == cw'(timeout_cycles_p));

    // counts consecutive strobed cycles with no slave response
    always_ff @(posedge clk_i) begin
      if (reset_i || !in_grant || wd_fire || resp || !s_stb_o)
        cnt_r <= '0;
      else
        cnt_r <= cnt_r + 1'b1;
    end
  end else begin : g_no_wd
    assign wd_fire = 1'b0;
  end

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Directed self-checking bench for bp_me_wb_arbiter, 2 masters,
// watchdog at 8 cycles.
module tb_bp_me_wb_arbiter;

  localparam int nm = 2;
  localparam int dw = 64;
  localparam int aw = 37;
  localparam int to = 8;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [nm*aw-1:0] m_adr_i;
  logic [nm*dw-1:0] m_dat_i;
  logic [nm*8-1:0]  m_sel_i;
  logic [nm-1:0]    m_we_i;
  logic [nm-1:0]    m_cyc_i;
  logic [nm-1:0]    m_stb_i;
  logic [nm*3-1:0]  m_cti_i;
  logic [nm*2-1:0]  m_bte_i;
  logic [dw-1:0]    m_dat_o;
  logic [nm-1:0]    m_ack_o;
  logic [nm-1:0]    m_err_o;
  logic [nm-1:0]    m_rty_o;
  logic [aw-1:0]    s_adr_o;
  logic [dw-1:0]    s_dat_o;
  logic [7:0]       s_sel_o;
  logic             s_we_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [dw-1:0]    s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;

  int errors = 0;
  int checks = 0;

  bp_me_wb_arbiter #(
    .num_masters_p(nm),
    .data_width_p(dw),
    .addr_width_p(aw),
    .timeout_cycles_p(to)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setm(input int k, input logic cyc, input logic stb,
                      input logic we, input logic [aw-1:0] adr,
                      input logic [2:0] cti);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = stb;
    m_we_i[k]           = we;
    m_adr_i[k*aw +: aw] = adr;
    m_cti_i[k*3 +: 3]   = cti;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '1;
    m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    m_cti_i = '0; m_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    step;
    step;
    reset_i = 1'b0;
  endtask

  initial begin
    do_reset;
    chk("rst_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_ack", 64'(m_ack_o), 64'd0);

    // single read by m0
    setm(0, 1, 1, 0, 37'h100, 3'd0);
    #1;
    chk("idle_cyc", 64'(s_cyc_o), 64'd0);
    chk("idle_adr", 64'(s_adr_o), 64'd0);
    step;
    chk("rd_cyc", 64'(s_cyc_o), 64'd1);
    chk("rd_stb", 64'(s_stb_o), 64'd1);
    chk("rd_adr", 64'(s_adr_o), 64'h100);
    chk("rd_we", 64'(s_we_o), 64'd0);
    s_ack_i = 1'b1;
    s_dat_i = 64'hDEADBEEF_CAFEF00D;
    #1;
    chk("rd_ack", 64'(m_ack_o), 64'b01);
    chk("rd_dat", m_dat_o, 64'hDEADBEEF_CAFEF00D);
    step;
    s_ack_i = 1'b0;
    setm(0, 0, 0, 0, 37'h100, 3'd0);
    step;
    step;

    // round robin after reset
    do_reset;
    setm(0, 1, 1, 0, 37'h200, 3'd0);
    setm(1, 1, 1, 0, 37'h300, 3'd0);
    step;
    chk("rr_first", 64'(s_adr_o), 64'h200);
    setm(0, 0, 0, 0, 37'h200, 3'd0);
    #1;
    chk("ho_t_cyc", 64'(s_cyc_o), 64'd0);
    step;
    chk("ho_t1_cyc", 64'(s_cyc_o), 64'd0);
    step;
    chk("ho_t2_cyc", 64'(s_cyc_o), 64'd1);
    chk("ho_t2_adr", 64'(s_adr_o), 64'h300);
    setm(1, 0, 0, 0, 37'h300, 3'd0);
    setm(0, 1, 1, 0, 37'h200, 3'd0);
    step;
    setm(1, 1, 1, 0, 37'h300, 3'd0);
    step;
    chk("rr_back_m0", 64'(s_adr_o), 64'h200);

    // locked burst by m0 while m1 waits
    for (int b = 0; b < 4; b++) begin
      setm(0, 1, 1, 0, 37'(32'h200 + b), (b == 3) ? 3'b111 : 3'b010);
      s_ack_i = 1'b1;
      #1;
      chk("burst_adr", 64'(s_adr_o), 64'(32'h200 + b));
      chk("burst_cti", 64'(s_cti_o), (b == 3) ? 64'd7 : 64'd2);
      chk("burst_ack", 64'(m_ack_o), 64'b01);
      step;
    end
    s_ack_i = 1'b0;
    setm(0, 0, 0, 0, 37'h200, 3'd0);
    #1;
    chk("burst_rel_ack", 64'(m_ack_o), 64'd0);
    step;
    chk("burst_idle_cyc", 64'(s_cyc_o), 64'd0);
    step;
    chk("burst_m1_adr", 64'(s_adr_o), 64'h300);

    // watchdog on a stalled m1 write
    setm(1, 1, 1, 1, 37'h300, 3'd0);
    for (int k = 1; k <= to; k++) begin
      #1;
      chk("wd_wait_err", 64'(m_err_o), 64'd0);
      chk("wd_wait_cyc", 64'(s_cyc_o), 64'd1);
      step;
    end
    #1;
    chk("wd_err", 64'(m_err_o), 64'b10);
    chk("wd_cyc", 64'(s_cyc_o), 64'd0);
    chk("wd_stb", 64'(s_stb_o), 64'd0);
    chk("wd_ack", 64'(m_ack_o), 64'd0);
    step;
    chk("wd_after_err", 64'(m_err_o), 64'd0);
    chk("wd_after_cyc", 64'(s_cyc_o), 64'd1);

    // err then rty routed to m1 only
    s_err_i = 1'b1;
    #1;
    chk("err_route", 64'(m_err_o), 64'b10);
    chk("err_ack", 64'(m_ack_o), 64'd0);
    chk("err_rty", 64'(m_rty_o), 64'd0);
    step;
    s_err_i = 1'b0;
    s_rty_i = 1'b1;
    #1;
    chk("rty_route", 64'(m_rty_o), 64'b10);
    chk("rty_err", 64'(m_err_o), 64'd0);
    step;
    s_rty_i = 1'b0;

    // reset mid-burst
    setm(1, 1, 1, 0, 37'h310, 3'b010);
    s_ack_i = 1'b1;
    #1;
    chk("mid_ack", 64'(m_ack_o), 64'b10);
    step;
    reset_i = 1'b1;
    #1;
    chk("mrst_cyc", 64'(s_cyc_o), 64'd0);
    chk("mrst_stb", 64'(s_stb_o), 64'd0);
    chk("mrst_ack", 64'(m_ack_o), 64'd0);
    step;
    step;
    reset_i = 1'b0;
    s_ack_i = 1'b0;
    setm(0, 1, 1, 0, 37'h200, 3'd0);
    #1;
    chk("post_rst_idle", 64'(s_cyc_o), 64'd0);
    step;
    chk("post_rst_m0", 64'(s_adr_o), 64'h200);
    chk("post_rst_cyc", 64'(s_cyc_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
